// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter
//   Sits between the FP decode stage and the functional units. Accepts tagged
//   operations over a valid/ready handshake, issues each one to its unit class
//   (core add/sub/mul/casts, FMA, iterative div/sqrt) and gathers every unit
//   completion into a multi-write output FIFO, so results may leave out of
//   order but always carry their tag.
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   in_valid_i / in_ready_o    op handshake; in_op_i, in_a/b/c_i, in_rm_i,
//                              in_prec_i, in_tag_i describe the op
//   issue_valid_o[2:0]         one-hot issue strobe {divsqrt, fma, core}
//   issue_op/a/b/c/rm/prec_o   op fields to the unit, zero when nothing issues
//   unit_valid_i[2:0]          per-unit completion strobe
//   unit_result_i, unit_flags_i per-unit result/flags, unit k at slice k
//   out_valid_o / out_ready_i  result handshake; out_result/flags/tag_o
//   spurious_o                 completion seen with no matching outstanding tag

package fpu_defs;
  localparam int C_CMD = 4;
  localparam int C_RM  = 3;
  localparam int C_PC  = 2;

  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD    = 4'h0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD    = 4'h1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD    = 4'h2;
  localparam logic [C_CMD-1:0] C_FPU_I2F_CMD    = 4'h3;
  localparam logic [C_CMD-1:0] C_FPU_F2I_CMD    = 4'h4;
  localparam logic [C_CMD-1:0] C_FPU_FMADD_CMD  = 4'h5;
  localparam logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = 4'h6;
  localparam logic [C_CMD-1:0] C_FPU_FNMADD_CMD = 4'h7;
  localparam logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = 4'h8;
  localparam logic [C_CMD-1:0] C_FPU_DIV_CMD    = 4'h9;
  localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD   = 4'hA;
endpackage

module fpu_issue_arbiter #(
  parameter int C_OP       = 32,
  parameter int C_CMD      = fpu_defs::C_CMD,
  parameter int C_RM       = fpu_defs::C_RM,
  parameter int C_PC       = fpu_defs::C_PC,
  parameter int C_FFLAG    = 5,
  parameter int C_TAG      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter logic [C_CMD-1:0] C_FPU_ADD_CMD    = fpu_defs::C_FPU_ADD_CMD,
  parameter logic [C_CMD-1:0] C_FPU_SUB_CMD    = fpu_defs::C_FPU_SUB_CMD,
  parameter logic [C_CMD-1:0] C_FPU_MUL_CMD    = fpu_defs::C_FPU_MUL_CMD,
  parameter logic [C_CMD-1:0] C_FPU_I2F_CMD    = fpu_defs::C_FPU_I2F_CMD,
  parameter logic [C_CMD-1:0] C_FPU_F2I_CMD    = fpu_defs::C_FPU_F2I_CMD,
  parameter logic [C_CMD-1:0] C_FPU_FMADD_CMD  = fpu_defs::C_FPU_FMADD_CMD,
  parameter logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = fpu_defs::C_FPU_FMSUB_CMD,
  parameter logic [C_CMD-1:0] C_FPU_FNMADD_CMD = fpu_defs::C_FPU_FNMADD_CMD,
  parameter logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = fpu_defs::C_FPU_FNMSUB_CMD,
  parameter logic [C_CMD-1:0] C_FPU_DIV_CMD    = fpu_defs::C_FPU_DIV_CMD,
  parameter logic [C_CMD-1:0] C_FPU_SQRT_CMD   = fpu_defs::C_FPU_SQRT_CMD
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [C_CMD-1:0]     in_op_i,
  input  logic [C_OP-1:0]      in_a_i,
  input  logic [C_OP-1:0]      in_b_i,
  input  logic [C_OP-1:0]      in_c_i,
  input  logic [C_RM-1:0]      in_rm_i,
  input  logic [C_PC-1:0]      in_prec_i,
  input  logic [C_TAG-1:0]     in_tag_i,
  output logic [2:0]           issue_valid_o,
  output logic [C_CMD-1:0]     issue_op_o,
  output logic [C_OP-1:0]      issue_a_o,
  output logic [C_OP-1:0]      issue_b_o,
  output logic [C_OP-1:0]      issue_c_o,
  output logic [C_RM-1:0]      issue_rm_o,
  output logic [C_PC-1:0]      issue_prec_o,
  input  logic [2:0]           unit_valid_i,
  input  logic [3*C_OP-1:0]    unit_result_i,
  input  logic [3*C_FFLAG-1:0] unit_flags_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [C_OP-1:0]      out_result_o,
  output logic [C_FFLAG-1:0]   out_flags_o,
  output logic [C_TAG-1:0]     out_tag_o,
  output logic                 spurious_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = C_OP + C_FFLAG + C_TAG;
  localparam int NSLOT = 4;
  localparam logic [C_FFLAG-1:0] FLAG_NV = {1'b1, {(C_FFLAG-1){1'b0}}};

  logic w_cls_core, w_cls_fma, w_cls_div, w_cls_ill;
  logic w_ready, w_accept, w_issue_any;
  logic [CW-1:0] r_outstanding;

  // in-order tag queues: index 0 = core, 1 = FMA
  logic [C_TAG-1:0] r_tq [2][FIFO_DEPTH];
  logic [AW-1:0]    r_tq_wp [2];
  logic [AW-1:0]    r_tq_rp [2];
  logic [CW-1:0]    r_tq_cnt [2];
  logic [1:0]       w_tq_push, w_tq_pop, w_tq_empty;

  logic             r_div_inflight;
  logic [C_TAG-1:0] r_div_tag;
  logic             w_div_done;

  logic             r_ill_valid;
  logic [C_TAG-1:0] r_ill_tag;

  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [NSLOT-1:0] w_wr_en;
  logic [EW-1:0]    w_wr_data [NSLOT];
  logic [AW-1:0]    w_wr_addr [NSLOT];
  logic [2:0]       w_nwr;
  logic             w_pop;

  always_comb begin
    w_cls_core = 1'b0;
    w_cls_fma  = 1'b0;
    w_cls_div  = 1'b0;
    w_cls_ill  = 1'b0;
    case (in_op_i)
      C_FPU_ADD_CMD, C_FPU_SUB_CMD, C_FPU_MUL_CMD,
      C_FPU_I2F_CMD, C_FPU_F2I_CMD:                   w_cls_core = 1'b1;
      C_FPU_FMADD_CMD, C_FPU_FMSUB_CMD,
      C_FPU_FNMADD_CMD, C_FPU_FNMSUB_CMD:             w_cls_fma  = 1'b1;
      C_FPU_DIV_CMD, C_FPU_SQRT_CMD:                  w_cls_div  = 1'b1;
      default:                                        w_cls_ill  = 1'b1;
    endcase
  end

  // every accepted op holds one output FIFO slot until popped, so writes never overflow
  assign w_ready     = (r_outstanding < CW'(FIFO_DEPTH)) & ~(w_cls_div & r_div_inflight);
  assign w_accept    = in_valid_i & w_ready;
  assign w_issue_any = w_accept & ~w_cls_ill;
  assign in_ready_o  = w_ready;

  assign issue_valid_o = {w_accept & w_cls_div, w_accept & w_cls_fma, w_accept & w_cls_core};
  assign issue_op_o    = w_issue_any ? in_op_i   : '0;
  assign issue_a_o     = w_issue_any ? in_a_i    : '0;
  assign issue_b_o     = w_issue_any ? in_b_i    : '0;
  assign issue_c_o     = w_issue_any ? in_c_i    : '0;
  assign issue_rm_o    = w_issue_any ? in_rm_i   : '0;
  assign issue_prec_o  = w_issue_any ? in_prec_i : '0;

  assign w_tq_push     = {w_accept & w_cls_fma, w_accept & w_cls_core};
  assign w_tq_empty[0] = (r_tq_cnt[0] == '0);
  assign w_tq_empty[1] = (r_tq_cnt[1] == '0);
  assign w_tq_pop      = unit_valid_i[1:0] & ~w_tq_empty;
  assign w_div_done    = unit_valid_i[2] & r_div_inflight;

  assign spurious_o = |(unit_valid_i & {~r_div_inflight, w_tq_empty});

  // completion slots packed in fixed order divsqrt, core, FMA, illegal
  always_comb begin
    w_wr_en      = {r_ill_valid, w_tq_pop[1], w_tq_pop[0], w_div_done};
    w_wr_data[0] = {unit_result_i[2*C_OP +: C_OP], unit_flags_i[2*C_FFLAG +: C_FFLAG], r_div_tag};
    w_wr_data[1] = {unit_result_i[0 +: C_OP], unit_flags_i[0 +: C_FFLAG], r_tq[0][r_tq_rp[0]]};
    w_wr_data[2] = {unit_result_i[C_OP +: C_OP], unit_flags_i[C_FFLAG +: C_FFLAG], r_tq[1][r_tq_rp[1]]};
    w_wr_data[3] = {{C_OP{1'b0}}, FLAG_NV, r_ill_tag};
    w_nwr        = '0;
    for (int s = 0; s < NSLOT; s++) begin
      w_wr_addr[s] = r_wr_ptr + AW'(w_nwr);
      w_nwr        = w_nwr + {2'b00, w_wr_en[s]};
    end
  end

  assign out_valid_o = (r_count != '0);
  assign w_pop       = out_valid_o & out_ready_i;
  assign {out_result_o, out_flags_o, out_tag_o} = out_valid_o ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 2; k++) begin
      if (w_tq_push[k]) r_tq[k][r_tq_wp[k]] <= in_tag_i;
    end
    for (int s = 0; s < NSLOT; s++) begin
      if (w_wr_en[s]) r_mem[w_wr_addr[s]] <= w_wr_data[s];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < 2; k++) begin
        r_tq_wp[k]  <= '0;
        r_tq_rp[k]  <= '0;
        r_tq_cnt[k] <= '0;
      end
      r_outstanding  <= '0;
      r_div_inflight <= 1'b0;
      r_div_tag      <= '0;
      r_ill_valid    <= 1'b0;
      r_ill_tag      <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_tq_push[k]) r_tq_wp[k] <= r_tq_wp[k] + AW'(1);
        if (w_tq_pop[k])  r_tq_rp[k] <= r_tq_rp[k] + AW'(1);
        r_tq_cnt[k] <= r_tq_cnt[k] + CW'(w_tq_push[k]) - CW'(w_tq_pop[k]);
      end
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_pop);
      // issue is blocked while in flight, so set and clear never coincide
      if (issue_valid_o[2]) begin
        r_div_inflight <= 1'b1;
        r_div_tag      <= in_tag_i;
      end else if (w_div_done) begin
        r_div_inflight <= 1'b0;
      end
      r_ill_valid <= w_accept & w_cls_ill;
      r_ill_tag   <= in_tag_i;
      r_wr_ptr    <= r_wr_ptr + AW'(w_nwr);
      r_rd_ptr    <= r_rd_ptr + AW'(w_pop);
      r_count     <= r_count + CW'(w_nwr) - CW'(w_pop);
    end
  end

endmodule
